// File: rtl/instruction_loader.sv
// instruction_loader: assembles big-endian words from a UART byte stream into instruction memory, stalling the pipeline until a halt word lands
module instruction_loader #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8,
  parameter int N_WORDS = 64,
  parameter int NB_WADDR = $clog2(N_WORDS),
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  input  logic                i_start,
  output logic                o_imem_wr_en,
  output logic [NB_WADDR-1:0] o_imem_wr_addr,
  output logic [NB_DATA-1:0]  o_imem_wr_data,
  output logic                o_stall,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overflow,
  output logic [NB_WADDR:0]   o_word_count
);

  localparam int NB_CNT = $clog2(NB_DATA / NB_BYTE);
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(NB_DATA / NB_BYTE - 1);
  localparam logic [NB_WADDR-1:0] LAST_ADDR = NB_WADDR'(N_WORDS - 1);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;

  state_t              r_state;
  logic [NB_CNT-1:0]   r_cnt;
  logic [NB_DATA-1:0]  r_word;
  logic [NB_WADDR-1:0] r_addr;
  logic                r_wr_en;
  logic [NB_WADDR-1:0] r_wr_addr;
  logic [NB_DATA-1:0]  r_wr_data;
  logic                r_stall;
  logic                r_busy;
  logic                r_done;
  logic                r_overflow;
  logic [NB_WADDR:0]   r_word_count;
  logic [NB_DATA-1:0]  w_next_word;

  assign w_next_word = {r_word[NB_DATA-NB_BYTE-1:0], i_rx_data};

  // Load FSM: byte assembly, one-cycle write pulse, halt/overflow termination
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_word       <= '0;
      r_addr       <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_stall      <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (i_start) begin
            r_state      <= RECV;
            r_cnt        <= '0;
            r_word       <= '0;
            r_addr       <= '0;
            r_word_count <= '0;
            r_stall      <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
          end
        end
        RECV: begin
          if (i_rx_valid) begin
            r_word <= w_next_word;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == LAST_BYTE) begin
              r_state   <= WRITE;
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_addr;
              r_wr_data <= w_next_word;
            end
          end
        end
        WRITE: begin
          r_word_count <= r_word_count + 1'b1;
          if (r_wr_data == HALT_WORD) begin
            r_state <= DONE;
            r_stall <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_addr == LAST_ADDR) begin
            r_state    <= ERROR;
            r_overflow <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_state <= RECV;
            r_addr  <= r_addr + 1'b1;
            // a byte arriving during the write is byte 0 of the next word
            if (i_rx_valid) begin
              r_word <= w_next_word;
              r_cnt  <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_imem_wr_en   = r_wr_en;
  assign o_imem_wr_addr = r_wr_addr;
  assign o_imem_wr_data = r_wr_data;
  assign o_stall        = r_stall;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_overflow     = r_overflow;
  assign o_word_count   = r_word_count;

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: drives byte-stream programs into a 64-word and a 4-word loader and checks writes and status against a word-level model
module tb_instruction_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic        d64_we, d64_stall, d64_busy, d64_done, d64_ovf;
  logic [5:0]  d64_wa;
  logic [31:0] d64_wd;
  logic [6:0]  d64_wc;
  logic        d4_we, d4_stall, d4_busy, d4_done, d4_ovf;
  logic [1:0]  d4_wa;
  logic [31:0] d4_wd;
  logic [2:0]  d4_wc;

  int total = 0;
  int bad = 0;
  int dbl = 0;
  logic p64 = 1'b0;
  logic p4 = 1'b0;

  logic [7:0]  prog[$];
  logic [63:0] mon64[$];
  logic [63:0] mon4[$];

  always #5 clk = ~clk;

  instruction_loader u_d64 (
    .i_clk(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_start(start),
    .o_imem_wr_en(d64_we), .o_imem_wr_addr(d64_wa), .o_imem_wr_data(d64_wd),
    .o_stall(d64_stall), .o_busy(d64_busy), .o_done(d64_done), .o_overflow(d64_ovf),
    .o_word_count(d64_wc)
  );

  instruction_loader #(.N_WORDS(4)) u_d4 (
    .i_clk(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_start(start),
    .o_imem_wr_en(d4_we), .o_imem_wr_addr(d4_wa), .o_imem_wr_data(d4_wd),
    .o_stall(d4_stall), .o_busy(d4_busy), .o_done(d4_done), .o_overflow(d4_ovf),
    .o_word_count(d4_wc)
  );

  // Capture every memory write and flag write-enable held for two cycles
  always @(negedge clk) begin
    if (d64_we) mon64.push_back({32'(d64_wa), d64_wd});
    if (d4_we) mon4.push_back({32'(d4_wa), d4_wd});
    if ((d64_we && p64) || (d4_we && p4)) dbl++;
    p64 <= d64_we;
    p4 <= d4_we;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    prog.push_back(w[31:24]);
    prog.push_back(w[23:16]);
    prog.push_back(w[15:8]);
    prog.push_back(w[7:0]);
  endtask

  task automatic send_prog(input int from, input bit gaps);
    for (int i = from; i < prog.size(); i++) begin
      send_byte(prog[i]);
      if (gaps) tick($urandom_range(0, 2));
    end
  endtask

  // Word-level model: words go to consecutive addresses until a halt word or the last slot
  task automatic verify(input string nm, input int n, input logic [63:0] got[$],
                        input logic done, input logic ovf, input logic stall,
                        input logic busy, input int wc);
    logic [63:0] exp[$];
    bit ed = 0;
    bit eo = 0;
    int nw = prog.size() / 4;
    for (int i = 0; i < nw && !ed && !eo; i++) begin
      logic [31:0] w;
      w = {prog[4*i], prog[4*i+1], prog[4*i+2], prog[4*i+3]};
      exp.push_back({32'(i), w});
      if (w == 32'hFFFFFFFF) ed = 1;
      else if (i == n - 1) eo = 1;
    end
    chk($sformatf("%s.nwr", nm), 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk($sformatf("%s.wr%0d", nm, i), got[i], exp[i]);
    chk($sformatf("%s.done", nm), 64'(done), 64'(ed));
    chk($sformatf("%s.ovf", nm), 64'(ovf), 64'(eo));
    chk($sformatf("%s.stall", nm), 64'(stall), 64'(!ed));
    chk($sformatf("%s.busy", nm), 64'(busy), 64'(!(ed || eo)));
    chk($sformatf("%s.wc", nm), 64'(wc), 64'(exp.size()));
  endtask

  task automatic verify_both(input string nm);
    verify({nm, ".d64"}, 64, mon64, d64_done, d64_ovf, d64_stall, d64_busy, 32'(d64_wc));
    verify({nm, ".d4"}, 4, mon4, d4_done, d4_ovf, d4_stall, d4_busy, 32'(d4_wc));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".we"}, 64'(d64_we), 64'(0));
    chk({nm, ".wa"}, 64'(d64_wa), 64'(0));
    chk({nm, ".wd"}, 64'(d64_wd), 64'(0));
    chk({nm, ".stall"}, 64'(d64_stall), 64'(1));
    chk({nm, ".busy"}, 64'(d64_busy), 64'(0));
    chk({nm, ".done"}, 64'(d64_done), 64'(0));
    chk({nm, ".ovf"}, 64'(d64_ovf), 64'(0));
    chk({nm, ".wc"}, 64'(d64_wc), 64'(0));
    chk({nm, ".d4we"}, 64'(d4_we), 64'(0));
    chk({nm, ".d4stall"}, 64'(d4_stall), 64'(1));
    chk({nm, ".d4ovf"}, 64'(d4_ovf), 64'(0));
    chk({nm, ".d4wc"}, 64'(d4_wc), 64'(0));
  endtask

  task automatic begin_load(input string nm);
    mon64.delete();
    mon4.delete();
    pulse_start();
    chk({nm, ".sbusy"}, 64'(d64_busy), 64'(1));
    chk({nm, ".sstall"}, 64'(d64_stall), 64'(1));
    chk({nm, ".sdone"}, 64'(d64_done), 64'(0));
    chk({nm, ".swc"}, 64'(d64_wc), 64'(0));
    chk({nm, ".sd4busy"}, 64'(d4_busy), 64'(1));
  endtask

  task automatic run_load(input string nm, input bit gaps);
    begin_load(nm);
    send_prog(0, gaps);
    tick(4);
    verify_both(nm);
  endtask

  initial begin
    tick(2);
    chk_reset("rst");
    rst_n = 1'b1;
    tick();

    // bytes while idle must be ignored
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    tick(2);
    chk("idle.nwr", 64'(mon64.size()), 64'(0));
    chk("idle.busy", 64'(d64_busy), 64'(0));
    chk("idle.done", 64'(d64_done), 64'(0));

    // directed program with exact halt timing
    prog.delete();
    push_word(32'h20010005);
    push_word(32'hFFFFFFFF);
    begin_load("t1");
    send_prog(0, 0);
    chk("t1.halt_we", 64'(d64_we), 64'(1));
    chk("t1.halt_wa", 64'(d64_wa), 64'(1));
    chk("t1.halt_wd", 64'(d64_wd), 64'hFFFFFFFF);
    chk("t1.pre_done", 64'(d64_done), 64'(0));
    tick();
    chk("t1.post_done", 64'(d64_done), 64'(1));
    chk("t1.post_stall", 64'(d64_stall), 64'(0));
    chk("t1.post_wc", 64'(d64_wc), 64'(2));
    tick(3);
    verify_both("t1");

    // back-to-back bytes, next word's byte 0 lands in the write cycle; restart from DONE
    prog.delete();
    push_word(32'h8C220004);
    push_word(32'hAC230008);
    push_word(32'hFFFFFFFF);
    run_load("t2", 0);

    // small memory overflows, large one keeps going to the halt
    prog.delete();
    for (int i = 1; i <= 5; i++) push_word(32'(i));
    push_word(32'hFFFFFFFF);
    run_load("t3", 1);

    // start pulsed mid-word is ignored
    prog.delete();
    push_word(32'h11223344);
    push_word(32'hFFFFFFFF);
    begin_load("t5");
    send_byte(prog[0]);
    send_byte(prog[1]);
    pulse_start();
    chk("t5.midwc", 64'(d64_wc), 64'(0));
    send_prog(2, 0);
    tick(4);
    verify_both("t5");

    // reset mid-word discards the partial word
    prog.delete();
    begin_load("t4");
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst_n = 1'b0;
    tick();
    chk_reset("t4rst");
    chk("t4.nwr", 64'(mon64.size()), 64'(0));
    rst_n = 1'b1;
    tick();
    push_word(32'h11223344);
    push_word(32'hFFFFFFFF);
    run_load("t4b", 0);

    // random programs of varied length and pacing
    for (int r = 0; r < 20; r++) begin
      prog.delete();
      for (int i = 0; i < int'($urandom_range(0, 6)); i++) push_word($urandom());
      push_word(32'hFFFFFFFF);
      run_load($sformatf("r%0d", r), $urandom_range(0, 1) == 1);
    end

    chk("dbl_pulse", 64'(dbl), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
